// File: rtl/word_asm_pkg.sv
// Shared types and sizing helpers for the nibble-to-word assembler.
package word_asm_pkg;

  // Two-state handshake FSM: gathering nibbles, or presenting a full word.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Number of nibbles that make up one assembled word.
  function automatic int nibs_per_word(input int word_w, input int nib_w);
    return word_w / nib_w;
  endfunction

  // Counter width able to hold the full range 0..nibs_per_word inclusive.
  function automatic int count_width(input int word_w, input int nib_w);
    return $clog2(word_w / nib_w) + 1;
  endfunction

endpackage

// File: rtl/nibble_shift_reg.sv
// Nibble-granular shift register. Shifts one nibble in per load, either
// toward the MSB end (first nibble ends up on top) or toward the LSB end
// (first nibble ends up at the bottom). Sync clear beats load.
module nibble_shift_reg #(
  parameter int WORD_W    = 32,
  parameter int NIB_W     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              clr,
  input  logic              load,
  input  logic [NIB_W-1:0]  din,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {q[WORD_W-NIB_W-1:0], din};
    end else begin : g_lsb_first
      assign shifted = {din, q[WORD_W-1:NIB_W]};
    end
  endgenerate

  // Word storage: async reset to zero, sync clear, shift on load.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/word_assembler_32.sv
// Packs a valid/ready stream of nibbles into one word and presents it on a
// valid/ready output. in_ready and out_valid decode the registered state
// only, so there is no combinational input-to-output path.
module word_assembler_32
  import word_asm_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NIB_W     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                              Clock,
  input  logic                              Clear,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NIB_W-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_W-1:0]                 out_data,
  output logic [$clog2(WORD_W/NIB_W):0]     nib_count
);

  localparam int N     = nibs_per_word(WORD_W, NIB_W);
  localparam int CNT_W = count_width(WORD_W, NIB_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WORD_W % NIB_W != 0) begin : g_width_check
      $error("word_assembler_32: WORD_W must be an integer multiple of NIB_W");
    end
  endgenerate

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              handoff;
  logic              sr_clr;

  // Handshake qualifiers; in_valid gates accept so X data never loads.
  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;
  // A handoff empties the word; flush discards it regardless.
  assign sr_clr  = flush | handoff;

  // State register.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: flush wins over accept and handoff.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && cnt == LAST) state_nxt = HOLD;
        HOLD:    if (handoff)               state_nxt = COLLECT;
        default:                            state_nxt = COLLECT;
      endcase
    end
  end

  // Output decode from the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Nibble counter: zeroed by flush or handoff, bumped on each accept.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      cnt <= '0;
    end else if (sr_clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign nib_count = cnt;

  nibble_shift_reg #(
    .WORD_W    (WORD_W),
    .NIB_W     (NIB_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .Clock (Clock),
    .Clear (Clear),
    .clr   (sr_clr),
    .load  (accept),
    .din   (in_data),
    .q     (out_data)
  );

endmodule
